// File: rtl/cldiv16.sv
// Bit-serial carryless (GF(2)[x]) divider: q = a / b, r = a mod b, with valid/ready handshakes.
// Optional build macro CLDIV_EARLY_EN skips the leading all-zero steps (latency 2N+s instead of 3N-1).
module cldiv16 #(
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dz
);
    localparam int unsigned QW = 2 * N;
    localparam int unsigned DW = 3 * N - 1;
    localparam int unsigned RW = N - 1;
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t        state;
    logic [DW-1:0] dd;
    logic [RW-1:0] rr;
    logic [RW-1:0] bnl;
    logic [QW-1:0] qs;
    logic [SW-1:0] sh_q;
    logic [CW-1:0] cnt;
    logic          bz;

    logic [SW-1:0] deg_c;
    logic [SW-1:0] sh_c;
    logic [RW-1:0] bn_c;
    logic [DW-1:0] d_init_c;
    logic [CW-1:0] cnt_init_c;
    logic [N-1:0]  t_c;
    logic [RW-1:0] r_nx_c;
    logic [QW-1:0] q_nx_c;

    // Normalise the divisor so its leading coefficient sits at bit N-1.
    always_comb begin
        deg_c = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) deg_c = SW'(i);
        end
        sh_c = SW'(N - 1) - deg_c;
        bn_c = RW'(b << sh_c);
`ifdef CLDIV_EARLY_EN
        // a << s with its N-1-s zero leading bits already consumed is simply a << (N-1).
        d_init_c   = DW'(a) << (N - 1);
        cnt_init_c = CW'(QW - 1) + CW'(sh_c);
`else
        d_init_c   = DW'(a) << sh_c;
        cnt_init_c = CW'(DW - 1);
`endif
    end

    // One long-division step: bring down the next dividend bit, subtract bn if the top bit is set.
    always_comb begin
        t_c    = {rr, dd[DW-1]};
        r_nx_c = t_c[N-1] ? (t_c[N-2:0] ^ bnl) : t_c[N-2:0];
        q_nx_c = {qs[QW-2:0], t_c[N-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dz        <= 1'b0;
            dd        <= '0;
            rr        <= '0;
            bnl       <= '0;
            qs        <= '0;
            sh_q      <= '0;
            cnt       <= '0;
            bz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= DIV;
                        in_ready <= 1'b0;
                        dd       <= d_init_c;
                        rr       <= '0;
                        qs       <= '0;
                        bnl      <= bn_c;
                        sh_q     <= sh_c;
                        cnt      <= cnt_init_c;
                        bz       <= (b == '0);
                    end
                end
                DIV: begin
                    if (bz) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        q         <= '0;
                        r         <= '0;
                        dz        <= 1'b1;
                    end else begin
                        dd  <= dd << 1;
                        rr  <= r_nx_c;
                        qs  <= q_nx_c;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            q         <= q_nx_c;
                            r         <= N'({1'b0, r_nx_c} >> sh_q);
                            dz        <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cldiv16.sv
// Self-checking bench for cldiv16: directed cases, random round trips against a polynomial long-division model,
// backpressure and mid-operation reset.
module tb_cldiv16;
    localparam int unsigned N = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*N-1:0]  a;
    logic [N-1:0]    b;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  q;
    logic [N-1:0]    r;
    logic            dz;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cldiv16 #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .dz(dz)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int degf(input logic [31:0] v);
        int d = -1;
        for (int i = 0; i < 32; i++) if (v[i]) d = i;
        return d;
    endfunction

    function automatic logic [31:0] clmul16(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p = '0;
        for (int i = 0; i < 16; i++) if (y[i]) p ^= 32'(x) << i;
        return p;
    endfunction

    // Textbook polynomial long division over GF(2).
    task automatic ref_div(input logic [31:0] av, input logic [15:0] bv,
                           output logic [31:0] qo, output logic [15:0] ro);
        logic [31:0] rem = av;
        int db = degf(32'(bv));
        qo = '0;
        ro = '0;
        if (bv != '0) begin
            for (int i = 31; i >= db; i--) begin
                if (rem[i]) begin
                    rem ^= 32'(bv) << (i - db);
                    qo[i - db] = 1'b1;
                end
            end
            ro = rem[15:0];
        end
    endtask

    function automatic int exp_lat(input logic [15:0] bv);
        if (bv == '0) return 1;
`ifdef CLDIV_EARLY_EN
        return 2 * N + (N - 1 - degf(32'(bv)));
`else
        return 3 * N - 1;
`endif
    endfunction

    // Issue one operation, check latency and result, then drain it.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [15:0] bv,
                          input logic [31:0] eq, input logic [15:0] er, input logic edz);
        int lat = 0;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = 16'($urandom);
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(bv)));
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_r"}, 64'(r), 64'(er));
        check({tag, "_dz"}, 64'(dz), 64'(edz));
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_hs"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    logic [31:0] eq, av;
    logic [15:0] er, x, y, z, bv;
    int          seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'({in_ready, out_valid, dz, q, r}), 64'({1'b1, 1'b0, 1'b0, 32'h0, 16'h0}));
        @(negedge clk) rst = 1'b0;

        run_op("d5_3",   32'h00000005, 16'h0003, 32'h00000003, 16'h0000, 1'b0);
        run_op("d7_3",   32'h00000007, 16'h0003, 32'h00000002, 16'h0001, 1'b0);
        run_op("dmax",   32'hFFFFFFFF, 16'h8000, 32'h0001FFFF, 16'h7FFF, 1'b0);
        run_op("dz",     32'h12345678, 16'h0000, 32'h00000000, 16'h0000, 1'b1);
        run_op("after_dz", 32'h00000005, 16'h0003, 32'h00000003, 16'h0000, 1'b0);
        run_op("b1",     32'hDEADBEEF, 16'h0001, 32'hDEADBEEF, 16'h0000, 1'b0);
        run_op("small_a", 32'h00000025, 16'h0481, 32'h00000000, 16'h0025, 1'b0);

        // Round trip: (x*y)/y == x, and adding a low-degree z lands in the remainder.
        for (int k = 0; k < 1000; k++) begin
            do x = 16'($urandom); while (x == '0);
            do y = 16'($urandom); while (y == '0);
            run_op("rt", clmul16(x, y), y, 32'(x), 16'h0, 1'b0);
        end
        for (int k = 0; k < 100; k++) begin
            do x = 16'($urandom); while (x == '0);
            do y = 16'($urandom); while (y < 16'h2);
            z = 16'($urandom) & 16'((32'h1 << degf(32'(y))) - 1);
            run_op("rtz", clmul16(x, y) ^ 32'(z), y, 32'(x), z, 1'b0);
        end
        for (int k = 0; k < 60; k++) begin
            av = $urandom;
            bv = 16'($urandom >> ($urandom_range(0, 15)));
            ref_div(av, bv, eq, er);
            run_op("rnd", av, bv, eq, er, bv == '0);
        end

        // Backpressure: result held, busy, and a stray in_valid is dropped.
        @(negedge clk);
        a = 32'h7; b = 16'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 200) begin @(posedge clk); #1; seen++; end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = (k == 3);
            a = 32'hFFFF0000; b = 16'h0005;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_hold", 64'({out_valid, in_ready, q, r}), 64'({1'b1, 1'b0, 32'h2, 16'h1}));
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        check("bp_no_queue", 64'(seen), 64'(0));

        // Reset in the middle of a division discards it.
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 16'h8000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst", 64'({in_ready, out_valid, dz, q, r}), 64'({1'b1, 1'b0, 1'b0, 32'h0, 16'h0}));
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mid_rst_silent", 64'(seen), 64'(0));
        run_op("post_rst", 32'h00000005, 16'h0003, 32'h00000003, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
